// File: rtl/bandit_ctrl.sv
// Slot-machine controller: tracks the credit balance, sequences a spin through the
// game stage, and applies payouts, refunds on timeout, and coin insertions.
module bandit_ctrl #(
  parameter logic [7:0]  INIT_CREDIT = 8'd10,
  parameter logic [7:0]  BET         = 8'd1,
  parameter logic [7:0]  COIN_VALUE  = 8'd5,
  parameter int unsigned REF_DIV     = 4,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_p,
  input  logic       coin_p,
  input  logic       turn_p,
  input  logic       score_sign,
  input  logic [3:0] result,
  output logic [3:0] cur_state,
  output logic       spin_p,
  output logic [1:0] refresh,
  output logic       ref_sign,
  output logic [7:0] credit,
  output logic       win_p
);

  localparam int DIV_W = (REF_DIV > 1) ? $clog2(REF_DIV) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REF_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    SPIN   = 4'b0010,
    SETTLE = 4'b0100,
    OVER   = 4'b1000
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [TO_W-1:0]  to_cnt, to_cnt_nxt;
  logic [1:0]       refresh_nxt;
  logic             ref_sign_nxt, spin_p_nxt, win_p_nxt;
  logic             lat_sign, lat_sign_nxt;
  logic [3:0]       lat_result, lat_result_nxt;

  logic       do_spin, timeout_hit, do_pay;
  logic [9:0] credit_sum;
  logic [7:0] credit_new;

  // Eligibility looks at the pre-coin balance; a turn on the expiry cycle wins over the refund.
  assign do_spin     = (state == IDLE) && start_p && (credit >= BET);
  assign timeout_hit = (state == SPIN) && !turn_p && (to_cnt == TO_LAST);
  assign do_pay      = (state == SETTLE) && lat_sign;

  // All credit movements in one cycle are summed before saturating at 255.
  assign credit_sum = {2'b00, credit}
                    + (coin_p      ? {2'b00, COIN_VALUE} : 10'd0)
                    + (do_pay      ? {6'd0, lat_result}  : 10'd0)
                    + (timeout_hit ? {2'b00, BET}        : 10'd0)
                    - (do_spin     ? {2'b00, BET}        : 10'd0);
  assign credit_new = (credit_sum > 10'd255) ? 8'hFF : credit_sum[7:0];

  assign cur_state = state;

  always_comb begin
    state_nxt      = state;
    div_cnt_nxt    = div_cnt;
    to_cnt_nxt     = to_cnt;
    refresh_nxt    = refresh;
    ref_sign_nxt   = 1'b0;
    spin_p_nxt     = 1'b0;
    win_p_nxt      = 1'b0;
    lat_sign_nxt   = lat_sign;
    lat_result_nxt = lat_result;

    case (state)
      IDLE: begin
        if (do_spin) begin
          state_nxt   = SPIN;
          spin_p_nxt  = 1'b1;
          div_cnt_nxt = '0;
          to_cnt_nxt  = '0;
        end
      end
      SPIN: begin
        if (turn_p) begin
          state_nxt      = SETTLE;
          lat_sign_nxt   = score_sign;
          lat_result_nxt = result;
        end else if (timeout_hit) begin
          state_nxt = IDLE;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
          if (div_cnt == DIV_LAST) begin
            div_cnt_nxt  = '0;
            ref_sign_nxt = 1'b1;
            refresh_nxt  = refresh + 2'd1;
          end else begin
            div_cnt_nxt = div_cnt + 1'b1;
          end
        end
      end
      SETTLE: begin
        win_p_nxt = lat_sign;
        state_nxt = (credit_new >= BET) ? IDLE : OVER;
      end
      OVER: begin
        if (coin_p) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div_cnt    <= '0;
      to_cnt     <= '0;
      refresh    <= 2'd0;
      ref_sign   <= 1'b0;
      spin_p     <= 1'b0;
      win_p      <= 1'b0;
      credit     <= INIT_CREDIT;
      lat_sign   <= 1'b0;
      lat_result <= 4'd0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      to_cnt     <= to_cnt_nxt;
      refresh    <= refresh_nxt;
      ref_sign   <= ref_sign_nxt;
      spin_p     <= spin_p_nxt;
      win_p      <= win_p_nxt;
      credit     <= credit_new;
      lat_sign   <= lat_sign_nxt;
      lat_result <= lat_result_nxt;
    end
  end

  a_onehot_state: assert property (@(posedge clk) disable iff (rst) $onehot(cur_state));
  a_spin_single:  assert property (@(posedge clk) disable iff (rst) spin_p |=> !spin_p);
  a_win_single:   assert property (@(posedge clk) disable iff (rst) win_p |=> !win_p);

endmodule

// File: tb/tb_bandit_ctrl.sv
// Scoreboard bench for bandit_ctrl: every observable output change is predicted
// up front and matched in order by an independent negedge monitor.
module tb_bandit_ctrl;

  localparam logic [3:0] ST_IDLE   = 4'b0001;
  localparam logic [3:0] ST_SPIN   = 4'b0010;
  localparam logic [3:0] ST_SETTLE = 4'b0100;
  localparam logic [3:0] ST_OVER   = 4'b1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_p, coin_p, turn_p, score_sign;
  logic [3:0] result;
  logic [3:0] cur_state;
  logic       spin_p, ref_sign, win_p;
  logic [1:0] refresh;
  logic [7:0] credit;

  always #5 clk = ~clk;

  bandit_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start_p    (start_p),
    .coin_p     (coin_p),
    .turn_p     (turn_p),
    .score_sign (score_sign),
    .result     (result),
    .cur_state  (cur_state),
    .spin_p     (spin_p),
    .refresh    (refresh),
    .ref_sign   (ref_sign),
    .credit     (credit),
    .win_p      (win_p)
  );

  typedef struct {
    string      name;
    logic [3:0] st;
    logic [7:0] cr;
    logic       sp;
    logic       rs;
    logic [1:0] rf;
    logic       wp;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  logic        rst_q;
  logic        was_rst;
  logic [16:0] snap, prev_snap;
  logic [1:0]  exp_rf;

  always @(posedge clk) rst_q <= rst;

  task automatic push_exp(input string name, input logic [3:0] st, input logic [7:0] cr,
                          input logic sp, input logic rs, input logic [1:0] rf, input logic wp);
    exp_t e;
    e.name = name; e.st = st; e.cr = cr; e.sp = sp; e.rs = rs; e.rf = rf; e.wp = wp;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (cur_state !== e.st || credit !== e.cr || spin_p !== e.sp ||
        ref_sign !== e.rs || refresh !== e.rf || win_p !== e.wp) begin
      errors++;
      $display("[TB] FAIL %s: got state=%b credit=%0d spin_p=%b ref_sign=%b refresh=%0d win_p=%b, expected state=%b credit=%0d spin_p=%b ref_sign=%b refresh=%0d win_p=%b",
               e.name, cur_state, credit, spin_p, ref_sign, refresh, win_p,
               e.st, e.cr, e.sp, e.rs, e.rf, e.wp);
    end
  endtask

  // Monitor: any output change, any pulse, or the first cycle out of reset is an event.
  initial begin
    was_rst   = 1'b1;
    prev_snap = '0;
    forever begin
      @(negedge clk);
      snap = {cur_state, credit, spin_p, ref_sign, refresh, win_p};
      if (rst_q !== 1'b0) begin
        was_rst = 1'b1;
      end else if (was_rst || snap !== prev_snap || spin_p || ref_sign || win_p) begin
        was_rst = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got state=%b credit=%0d spin_p=%b ref_sign=%b refresh=%0d win_p=%b, expected no change",
                   cur_state, credit, spin_p, ref_sign, refresh, win_p);
        end else begin
          checkOutput(exp_q.pop_front());
        end
      end
      prev_snap = snap;
    end
  end

  task automatic applyStimulus(input logic s, input logic c, input logic t,
                               input logic sg, input logic [3:0] r);
    start_p = s; coin_p = c; turn_p = t; score_sign = sg; result = r;
    @(posedge clk); #1;
    start_p = 1'b0; coin_p = 1'b0; turn_p = 1'b0; score_sign = 1'b0; result = 4'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
  endtask

  task automatic push_ticks(input string name, input logic [3:0] st, input logic [7:0] cr, input int n);
    for (int j = 0; j < n; j++) begin
      exp_rf = exp_rf + 2'd1;
      push_exp(name, st, cr, 1'b0, 1'b1, exp_rf, 1'b0);
      push_exp({name, "_drop"}, st, cr, 1'b0, 1'b0, exp_rf, 1'b0);
    end
  endtask

  initial begin
    exp_t e;
    start_p = 1'b0; coin_p = 1'b0; turn_p = 1'b0; score_sign = 1'b0; result = 4'd0;
    exp_rf  = 2'd0;

    push_exp("reset", ST_IDLE, 8'd10, 1'b0, 1'b0, 2'd0, 1'b0);
    do_reset();
    idle(2);

    // Spin, two refresh ticks, then a win of 5
    push_exp("spin_start",  ST_SPIN, 8'd9, 1'b1, 1'b0, 2'd0, 1'b0);
    push_exp("spin_p_drop", ST_SPIN, 8'd9, 1'b0, 1'b0, 2'd0, 1'b0);
    push_ticks("ref_tick", ST_SPIN, 8'd9, 2);
    push_exp("settle_win",  ST_SETTLE, 8'd9,  1'b0, 1'b0, 2'd2, 1'b0);
    push_exp("payout",      ST_IDLE,   8'd14, 1'b0, 1'b0, 2'd2, 1'b1);
    push_exp("win_p_drop",  ST_IDLE,   8'd14, 1'b0, 1'b0, 2'd2, 1'b0);
    applyStimulus(1, 0, 0, 0, 4'd0);
    idle(9);
    applyStimulus(0, 0, 1, 1, 4'd5);
    idle(3);

    // Timeout with refund
    push_exp("to_spin",     ST_SPIN, 8'd13, 1'b1, 1'b0, exp_rf, 1'b0);
    push_exp("to_spin_drop", ST_SPIN, 8'd13, 1'b0, 1'b0, exp_rf, 1'b0);
    push_ticks("to_tick", ST_SPIN, 8'd13, 15);
    push_exp("timeout_refund", ST_IDLE, 8'd14, 1'b0, 1'b0, exp_rf, 1'b0);
    applyStimulus(1, 0, 0, 0, 4'd0);
    idle(70);

    // turn_p on the expiry cycle settles without refund
    push_exp("exp_spin",      ST_SPIN, 8'd13, 1'b1, 1'b0, exp_rf, 1'b0);
    push_exp("exp_spin_drop", ST_SPIN, 8'd13, 1'b0, 1'b0, exp_rf, 1'b0);
    push_ticks("exp_tick", ST_SPIN, 8'd13, 15);
    push_exp("expiry_settle", ST_SETTLE, 8'd13, 1'b0, 1'b0, exp_rf, 1'b0);
    push_exp("expiry_loss",   ST_IDLE,   8'd13, 1'b0, 1'b0, exp_rf, 1'b0);
    applyStimulus(1, 0, 0, 0, 4'd0);
    idle(63);
    applyStimulus(0, 0, 1, 0, 4'd7);
    idle(3);

    // Coin coincident with deduction, then reset mid-spin: no refund
    push_exp("spin_with_coin", ST_SPIN, 8'd17, 1'b1, 1'b0, exp_rf, 1'b0);
    push_exp("reset_mid_spin", ST_IDLE, 8'd10, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1, 1, 0, 0, 4'd0);
    do_reset();
    exp_rf = 2'd0;
    idle(2);

    // Ten losing spins drain the balance into OVER
    for (int i = 0; i < 10; i++) begin
      push_exp("loss_spin",   ST_SPIN,   8'(9 - i), 1'b1, 1'b0, 2'd0, 1'b0);
      push_exp("loss_settle", ST_SETTLE, 8'(9 - i), 1'b0, 1'b0, 2'd0, 1'b0);
      push_exp("loss_done", (i < 9) ? ST_IDLE : ST_OVER, 8'(9 - i), 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(1, 0, 0, 0, 4'd0);
      applyStimulus(0, 0, 1, 0, 4'd3);
      idle(1);
    end
    applyStimulus(1, 0, 0, 0, 4'd0);
    applyStimulus(0, 0, 1, 1, 4'd9);
    idle(2);
    push_exp("over_coin", ST_IDLE, 8'd5, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(0, 1, 0, 0, 4'd0);
    idle(1);

    // Build to 250, then win 15 with a coin during the payout: saturate at 255
    for (int k = 1; k <= 49; k++) begin
      push_exp("coin_add", ST_IDLE, 8'(5 + 5 * k), 1'b0, 1'b0, 2'd0, 1'b0);
      applyStimulus(0, 1, 0, 0, 4'd0);
    end
    push_exp("sat_spin",   ST_SPIN,   8'd249, 1'b1, 1'b0, 2'd0, 1'b0);
    push_exp("sat_settle", ST_SETTLE, 8'd249, 1'b0, 1'b0, 2'd0, 1'b0);
    push_exp("sat_payout", ST_IDLE,   8'd255, 1'b0, 1'b0, 2'd0, 1'b1);
    push_exp("sat_win_drop", ST_IDLE, 8'd255, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1, 0, 0, 0, 4'd0);
    applyStimulus(0, 0, 1, 1, 4'd15);
    applyStimulus(0, 1, 0, 0, 4'd0);
    idle(3);
    push_exp("post_sat_spin",   ST_SPIN,   8'd254, 1'b1, 1'b0, 2'd0, 1'b0);
    push_exp("post_sat_settle", ST_SETTLE, 8'd254, 1'b0, 1'b0, 2'd0, 1'b0);
    push_exp("post_sat_idle",   ST_IDLE,   8'd254, 1'b0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1, 0, 0, 0, 4'd0);
    applyStimulus(0, 0, 1, 0, 4'd2);
    idle(5);

    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("[TB] FAIL %s: got no event, expected state=%b credit=%0d", e.name, e.st, e.cr);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
